gpio_pin_filter: RTL and testbench
==================================

GPIO_PIN_FILTER -- requirements
Module: gpio_pin_filter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, number of pins per port; CNT_W, default 8, debounce counter width.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pin_in  input  WIDTH  raw asynchronous pad levels, upstream of soc_top gpio_pin_in_b/c/d.
REQ-005 debounce_len  input  CNT_W  consecutive stable cycles required before accepting a new level; 0 is treated as 1.
REQ-006 pcmsk  input  WIDTH  per-pin pin-change interrupt enable.
REQ-007 pcif_clr  input  WIDTH  per-pin write-1-to-clear pulse for pcif.
REQ-008 pin_filt  output  WIDTH  synchronized, debounced level; drives the SoC gpio_pin_in_x port.
REQ-009 pin_rise  output  WIDTH  one-cycle pulse per pin on an accepted 0->1 transition.
REQ-010 pin_fall  output  WIDTH  one-cycle pulse per pin on an accepted 1->0 transition.
REQ-011 pcif  output  WIDTH  sticky pin-change flags.
REQ-012 pc_irq  output  1  OR-reduction of pcif.

Function
REQ-013 Each pin SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-014 Each pin SHALL have an independent counter cnt[CNT_W] and an accepted level pin_filt.
REQ-015 Counter rule: sync2 == pin_filt -> cnt cleared to 0; sync2 != pin_filt -> cnt increments, saturating at all-ones.
REQ-016 pin_filt SHALL take sync2, and cnt SHALL clear, on the edge where sync2 != pin_filt and cnt+1 >= max(debounce_len,1).
REQ-017 Latency: a clean level change on pin_in settling before edge k SHALL appear on pin_filt after edge k+1+max(debounce_len,1); with debounce_len 0 or 1, after edge k+2.
REQ-018 A glitch shorter than max(debounce_len,1) synchronized cycles SHALL NOT change pin_filt, pin_rise, pin_fall or pcif.
REQ-019 debounce_len changes mid-count SHALL take effect immediately against the current cnt, with no reset of cnt.
REQ-020 pin_rise/pin_fall SHALL be registered and assert in the same cycle pin_filt changes, for exactly one cycle; they SHALL never both be high for the same pin.
REQ-021 pcif[i] SHALL set on the edge pin_filt[i] changes if pcmsk[i]=1 at that edge.
REQ-022 pcif[i] SHALL clear on an edge where pcif_clr[i]=1; simultaneous set and clear SHALL leave pcif[i]=1 (set wins).
REQ-023 Deasserting pcmsk[i] SHALL NOT clear an already-set pcif[i].
REQ-024 pc_irq SHALL be combinational |pcif, with no additional delay.
REQ-025 Pins SHALL be fully independent; simultaneous changes on several pins SHALL each be processed in the same cycle.

Reset
REQ-026 While rst=1, sync1, sync2, cnt, pin_filt, pin_rise, pin_fall and pcif SHALL be 0, and pc_irq SHALL be 0.
REQ-027 After rst is released with pin_in high, the pin SHALL be treated as a 0->1 transition under REQ-016/017, producing pin_rise and, if masked, pcif.
REQ-028 rst asserted mid-count SHALL discard the pending transition with no pulse emitted.

Verification
REQ-029 debounce_len=0, pcmsk=0x01, pin_in 0x00->0x01 before edge k -> pin_filt=0x01 and pin_rise=0x01 at edge k+2; pcif=0x01; pc_irq=1.
REQ-030 debounce_len=4, pin_in[3] high for 3 cycles then low -> pin_filt, pin_rise and pcif stay 0x00; held high for 4 cycles -> pin_filt[3]=1 at edge k+5.
REQ-031 pcif=0x01 with pcif_clr=0x01 on the same edge as a new masked fall on pin 0 -> pcif stays 0x01; a clear on the next edge -> pcif=0x00 and pc_irq=0.
REQ-032 pcmsk=0x00, pin_in toggles 0x00->0xFF -> pin_filt=0xFF, pin_rise=0xFF for one cycle, pcif=0x00.
REQ-033 debounce_len=8, rst pulsed at cnt=5 with pin_in=0x80 held -> all outputs are 0; after release, pin_filt=0x80 at edge 9 after release.
REQ-034 pin_in=0x0F driven during and after reset, debounce_len=2, pcmsk=0xFF -> at edge 3 after release, pin_filt=0x0F, pin_rise=0x0F and pcif=0x0F.

Source files
------------

// File: rtl/gpio_pin_filter.sv
// Per-pin GPIO input conditioning: two-flop synchronizer, saturating debounce
// counter, registered edge pulses and sticky, maskable pin-change flags.
module gpio_pin_filter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [CNT_W-1:0] debounce_len,
    input  logic [WIDTH-1:0] pcmsk,
    input  logic [WIDTH-1:0] pcif_clr,
    output logic [WIDTH-1:0] pin_filt,
    output logic [WIDTH-1:0] pin_rise,
    output logic [WIDTH-1:0] pin_fall,
    output logic [WIDTH-1:0] pcif,
    output logic             pc_irq
);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            filt_q;
    logic [WIDTH-1:0]            filt_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic [WIDTH-1:0]            pcif_q;
    logic [WIDTH-1:0]            pcif_d;
    logic [CNT_W:0]              eff_len_s;
    logic [CNT_W:0]              cnt_next_s;
    logic                        differ_s;
    logic                        accept_s;

    // Debounce length 0 behaves exactly like 1; extended by one bit so the
    // compare against cnt+1 cannot wrap when cnt is saturated.
    always_comb begin
        if (debounce_len == {CNT_W{1'b0}}) begin
            eff_len_s = {{CNT_W{1'b0}}, 1'b1};
        end else begin
            eff_len_s = {1'b0, debounce_len};
        end
    end

    // Per-pin counter, acceptance, edge pulse and sticky flag next-state.
    always_comb begin
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        rise_d     = {WIDTH{1'b0}};
        fall_d     = {WIDTH{1'b0}};
        pcif_d     = pcif_q & ~pcif_clr;
        cnt_next_s = {(CNT_W + 1){1'b0}};
        differ_s   = 1'b0;
        accept_s   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            differ_s   = sync2_q[i] ^ filt_q[i];
            cnt_next_s = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
            accept_s   = differ_s && (cnt_next_s >= eff_len_s);
            if (!differ_s || accept_s) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (&cnt_q[i]) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_next_s[CNT_W-1:0];
            end
            if (accept_s) begin
                filt_d[i] = sync2_q[i];
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
                // Set is applied after the clear so a coincident clear loses.
                if (pcmsk[i]) begin
                    pcif_d[i] = 1'b1;
                end else begin
                    pcif_d[i] = pcif_d[i];
                end
            end else begin
                filt_d[i] = filt_q[i];
            end
        end
    end

    // State registers; reset discards any in-flight transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
            cnt_q   <= '0;
            filt_q  <= {WIDTH{1'b0}};
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            pcif_q  <= {WIDTH{1'b0}};
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pcif_q  <= pcif_d;
        end
    end

    assign pin_filt = filt_q;
    assign pin_rise = rise_q;
    assign pin_fall = fall_q;
    assign pcif     = pcif_q;
    assign pc_irq   = |pcif_q;

endmodule

// File: tb/tb_gpio_pin_filter.sv
// Directed self-checking bench for gpio_pin_filter with hand-computed
// expectations; outputs are sampled 1 time unit after each rising edge.
module tb_gpio_pin_filter;

    logic       clk;
    logic       rst;
    logic [7:0] pin_in;
    logic [7:0] debounce_len;
    logic [7:0] pcmsk;
    logic [7:0] pcif_clr;
    logic [7:0] pin_filt;
    logic [7:0] pin_rise;
    logic [7:0] pin_fall;
    logic [7:0] pcif;
    logic       pc_irq;

    int checks_cnt;
    int fail_cnt;
    logic [7:0] seen_s;

    gpio_pin_filter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pin_in       (pin_in),
        .debounce_len (debounce_len),
        .pcmsk        (pcmsk),
        .pcif_clr     (pcif_clr),
        .pin_filt     (pin_filt),
        .pin_rise     (pin_rise),
        .pin_fall     (pin_fall),
        .pcif         (pcif),
        .pc_irq       (pc_irq)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed scenarios in sequence.
    initial begin
        checks_cnt   = 0;
        fail_cnt     = 0;
        rst          = 1'b1;
        pin_in       = 8'h00;
        debounce_len = 8'd0;
        pcmsk        = 8'h00;
        pcif_clr     = 8'h00;

        step(2);
        check_eq("rst_filt", {24'd0, pin_filt}, 32'h0);
        check_eq("rst_rise", {24'd0, pin_rise}, 32'h0);
        check_eq("rst_pcif", {24'd0, pcif}, 32'h0);
        check_eq("rst_irq", {31'd0, pc_irq}, 32'h0);
        rst = 1'b0;
        step(4);

        // Minimum debounce: 0x00 -> 0x01 lands at edge k+2.
        pcmsk  = 8'h01;
        pin_in = 8'h01;
        step(1);
        check_eq("len0_k", {24'd0, pin_filt}, 32'h00);
        step(1);
        check_eq("len0_k1", {24'd0, pin_filt}, 32'h00);
        step(1);
        check_eq("len0_filt", {24'd0, pin_filt}, 32'h01);
        check_eq("len0_rise", {24'd0, pin_rise}, 32'h01);
        check_eq("len0_fall", {24'd0, pin_fall}, 32'h00);
        check_eq("len0_pcif", {24'd0, pcif}, 32'h01);
        check_eq("len0_irq", {31'd0, pc_irq}, 32'h1);
        step(1);
        check_eq("len0_rise_1cyc", {24'd0, pin_rise}, 32'h00);
        pcif_clr = 8'h01;
        step(1);
        pcif_clr = 8'h00;
        check_eq("clr_pcif", {24'd0, pcif}, 32'h00);
        check_eq("clr_irq", {31'd0, pc_irq}, 32'h0);

        // Debounce 4: a 3-cycle glitch on pin 3 is rejected.
        debounce_len = 8'd4;
        pcmsk        = 8'h08;
        pin_in       = 8'h09;
        step(3);
        pin_in = 8'h01;
        seen_s = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen_s = seen_s | pin_rise | pin_fall;
        end
        check_eq("glitch_pulse", {24'd0, seen_s}, 32'h00);
        check_eq("glitch_filt", {24'd0, pin_filt}, 32'h01);
        check_eq("glitch_pcif", {24'd0, pcif}, 32'h00);

        // Held 4 cycles: accepted at edge k+5.
        pin_in = 8'h09;
        step(5);
        check_eq("len4_k4", {24'd0, pin_filt}, 32'h01);
        step(1);
        check_eq("len4_k5_filt", {24'd0, pin_filt}, 32'h09);
        check_eq("len4_k5_rise", {24'd0, pin_rise}, 32'h08);
        check_eq("len4_k5_pcif", {24'd0, pcif}, 32'h08);
        pcif_clr = 8'h08;
        step(1);
        pcif_clr = 8'h00;
        check_eq("len4_clr", {24'd0, pcif}, 32'h00);

        // Set wins over a coincident clear.
        debounce_len = 8'd1;
        pcmsk        = 8'h01;
        pin_in       = 8'h08;
        step(3);
        check_eq("fall_pcif", {24'd0, pcif}, 32'h01);
        check_eq("fall_pulse", {24'd0, pin_fall}, 32'h01);
        pin_in = 8'h09;
        step(3);
        check_eq("rise_pcif", {24'd0, pcif}, 32'h01);
        pin_in = 8'h08;
        step(2);
        pcif_clr = 8'h01;
        step(1);
        check_eq("setwin_fall", {24'd0, pin_fall}, 32'h01);
        check_eq("setwin_rise", {24'd0, pin_rise}, 32'h00);
        check_eq("setwin_pcif", {24'd0, pcif}, 32'h01);
        step(1);
        pcif_clr = 8'h00;
        check_eq("nextclr_pcif", {24'd0, pcif}, 32'h00);
        check_eq("nextclr_irq", {31'd0, pc_irq}, 32'h0);

        // All pins together, unmasked.
        pcmsk        = 8'h00;
        debounce_len = 8'd0;
        pin_in       = 8'h00;
        step(4);
        pin_in = 8'hFF;
        step(2);
        check_eq("all_k1", {24'd0, pin_filt}, 32'h00);
        step(1);
        check_eq("all_filt", {24'd0, pin_filt}, 32'hFF);
        check_eq("all_rise", {24'd0, pin_rise}, 32'hFF);
        check_eq("all_pcif", {24'd0, pcif}, 32'h00);
        step(1);
        check_eq("all_rise_1cyc", {24'd0, pin_rise}, 32'h00);

        // Length shortened mid-count takes effect against the live counter.
        debounce_len = 8'd8;
        pin_in       = 8'h00;
        step(4);
        check_eq("mid_k3", {24'd0, pin_filt}, 32'hFF);
        debounce_len = 8'd3;
        step(1);
        check_eq("mid_filt", {24'd0, pin_filt}, 32'h00);
        check_eq("mid_fall", {24'd0, pin_fall}, 32'hFF);

        // Reset mid-count discards the pending rise.
        debounce_len = 8'd8;
        pcmsk        = 8'h80;
        pin_in       = 8'h80;
        step(7);
        rst = 1'b1;
        #1;
        check_eq("midrst_filt", {24'd0, pin_filt}, 32'h00);
        check_eq("midrst_rise", {24'd0, pin_rise}, 32'h00);
        check_eq("midrst_pcif", {24'd0, pcif}, 32'h00);
        step(2);
        rst = 1'b0;
        // First rising edge after release is numbered edge 0.
        step(9);
        check_eq("rel_e8", {24'd0, pin_filt}, 32'h00);
        step(1);
        check_eq("rel_e9_filt", {24'd0, pin_filt}, 32'h80);
        check_eq("rel_e9_rise", {24'd0, pin_rise}, 32'h80);
        check_eq("rel_e9_pcif", {24'd0, pcif}, 32'h80);

        // Pins high through reset are seen as rising after release.
        rst          = 1'b1;
        pin_in       = 8'h0F;
        debounce_len = 8'd2;
        pcmsk        = 8'hFF;
        step(3);
        check_eq("hi_rst_filt", {24'd0, pin_filt}, 32'h00);
        check_eq("hi_rst_irq", {31'd0, pc_irq}, 32'h0);
        rst = 1'b0;
        step(3);
        check_eq("hi_e2", {24'd0, pin_filt}, 32'h00);
        step(1);
        check_eq("hi_e3_filt", {24'd0, pin_filt}, 32'h0F);
        check_eq("hi_e3_rise", {24'd0, pin_rise}, 32'h0F);
        check_eq("hi_e3_pcif", {24'd0, pcif}, 32'h0F);
        check_eq("hi_e3_irq", {31'd0, pc_irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
